// File: rtl/tl_display_scan_pkg.sv
// Shared types, lamp-state encodings and the seven-segment hex table for the display stage.
// Latency: none; constants, types and a pure function only.
// Backpressure: not applicable; nothing here holds state or handshakes.
package tl_display_scan_pkg;

    // Lamp state as seen on {a_l, b_l}
    localparam logic [1:0] S0 = 2'b00;  // all-stop, steady amber
    localparam logic [1:0] S1 = 2'b01;  // street B go
    localparam logic [1:0] S2 = 2'b10;  // street A go
    localparam logic [1:0] S3 = 2'b11;  // flashing amber

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Discrete lamp outputs, kept together so they register as one word
    typedef struct packed {
        logic a_grn;
        logic a_red;
        logic b_grn;
        logic b_red;
        logic amber;
    } lamp_t;

    // Segment pattern {g,f,e,d,c,b,a}, active-high, for one hex digit
    function automatic logic [6:0] hex2seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/tl_display_scan_if.sv
// Bundle between the traffic-light controller and its display/lamp driver stage.
// Latency: none; wires only.
// Backpressure: none; the controller's timer/lamp values are sampled every clock.
interface tl_display_scan_if;
    logic [3:0] a_ti_l;
    logic [3:0] a_ti_h;
    logic [3:0] b_ti_l;
    logic [3:0] b_ti_h;
    logic       a_l;
    logic       b_l;
    logic [6:0] seg;
    logic [3:0] dig_en;
    logic       a_grn;
    logic       a_red;
    logic       b_grn;
    logic       b_red;
    logic       amber;

    // Controller side: supplies timers and lamp state, observes the display
    modport master (
        output a_ti_l, a_ti_h, b_ti_l, b_ti_h, a_l, b_l,
        input  seg, dig_en, a_grn, a_red, b_grn, b_red, amber
    );

    // Display stage side
    modport slave (
        input  a_ti_l, a_ti_h, b_ti_l, b_ti_h, a_l, b_l,
        output seg, dig_en, a_grn, a_red, b_grn, b_red, amber
    );
endinterface

// File: rtl/tl_display_scan_seg7_hex_dec.sv
// Combinational hex-digit to seven-segment decoder.
// Latency: zero cycles.
// Backpressure: none.
module seg7_hex_dec
    import tl_display_scan_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    // Pure table lookup
    always_comb begin
        seg = hex2seg(nib);
    end

endmodule

// File: rtl/tl_display_scan.sv
// Scans a 4-digit multiplexed seven-segment display from a frame snapshot and drives the lamps.
// Latency: seg/dig_en and lamps are one clock behind idx/snapshot and live a_l/b_l.
// Backpressure: none; inputs are sampled freely and the scan never stalls.
module tl_display_scan
    import tl_display_scan_pkg::*;
#(
    parameter int SCAN_DIV  = 4,
    parameter int BLINK_DIV = 64,
    parameter int LZB       = 1
) (
    input  logic              clk,
    input  logic              rst,
    tl_display_scan_if.slave  bus
);

    localparam int PW = $clog2(SCAN_DIV) + 1;
    localparam int BW = $clog2(BLINK_DIV) + 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   snap_q, snap_d;
    logic          load_pend_q, load_pend_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_ph_q, blink_ph_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    dig_en_q, dig_en_d;
    lamp_t         lamp_q, lamp_d;

    logic [15:0]   live_dat;
    logic [3:0]    cur_nib;
    logic [6:0]    dec_seg;
    logic          scan_wrap;

    assign live_dat = {bus.b_ti_h, bus.b_ti_l, bus.a_ti_h, bus.a_ti_l};
    assign cur_nib  = snap_q[{idx_q, 2'b00} +: 4];

    seg7_hex_dec u_dec (
        .nib (cur_nib),
        .seg (dec_seg)
    );

    // Digit scan, frame snapshot and registered segment/enable selection
    always_comb begin
        scan_wrap   = (presc_q == PW'(SCAN_DIV - 1));
        presc_d     = presc_q;
        idx_d       = idx_q;
        snap_d      = snap_q;
        load_pend_d = load_pend_q;
        seg_d       = SEG_BLANK;
        dig_en_d    = 4'b0000;
        if (load_pend_q) begin
            // First clock out of reset only loads the snapshot; the scan holds so that
            // the very first digit shown already comes from live data and gets its full dwell.
            snap_d      = live_dat;
            load_pend_d = 1'b0;
        end else begin
            presc_d = scan_wrap ? '0 : presc_q + PW'(1);
            if (scan_wrap) begin
                idx_d = idx_q + 2'd1;
            end
            // Recapture only between frames so one frame never mixes old and new timers
            if (scan_wrap && idx_q == 2'd3) begin
                snap_d = live_dat;
            end
            dig_en_d = 4'b0001 << idx_q;
            if (LZB != 0 && idx_q[0] && cur_nib == 4'h0) begin
                seg_d = SEG_BLANK;
            end else begin
                seg_d = dec_seg;
            end
        end
    end

    // Free-running amber blinker
    always_comb begin
        if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            blink_ph_d  = ~blink_ph_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
            blink_ph_d  = blink_ph_q;
        end
    end

    // Lamp decode from the live state bits; greens are mutually exclusive by construction
    always_comb begin
        lamp_d = '0;
        case ({bus.a_l, bus.b_l})
            S2:      begin lamp_d.a_grn = 1'b1; lamp_d.b_red = 1'b1; end
            S1:      begin lamp_d.b_grn = 1'b1; lamp_d.a_red = 1'b1; end
            S0:      lamp_d.amber = 1'b1;
            default: lamp_d.amber = blink_ph_q;
        endcase
    end

    // State and output registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q     <= '0;
            idx_q       <= 2'd0;
            snap_q      <= 16'h0000;
            load_pend_q <= 1'b1;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            seg_q       <= SEG_BLANK;
            dig_en_q    <= 4'b0000;
            lamp_q      <= '0;
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            snap_q      <= snap_d;
            load_pend_q <= load_pend_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            seg_q       <= seg_d;
            dig_en_q    <= dig_en_d;
            lamp_q      <= lamp_d;
        end
    end

    assign bus.seg    = seg_q;
    assign bus.dig_en = dig_en_q;
    assign bus.a_grn  = lamp_q.a_grn;
    assign bus.a_red  = lamp_q.a_red;
    assign bus.b_grn  = lamp_q.b_grn;
    assign bus.b_red  = lamp_q.b_red;
    assign bus.amber  = lamp_q.amber;

endmodule

// File: tb/tb_tl_display_scan.sv
// Directed bench for the display/lamp stage with a cycle-timeline scoreboard.
// Latency: expects one clock from idx/snapshot/lamp state to outputs.
// Backpressure: none exercised; the DUT free-runs.
module tb_tl_display_scan;

    typedef struct packed {
        logic [3:0] dig;
        logic [6:0] seg;
        logic [4:0] lamps;   // {a_grn, a_red, b_grn, b_red, amber}
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    tl_display_scan_if bus ();

    tl_display_scan #(
        .SCAN_DIV  (4),
        .BLINK_DIV (8),
        .LZB       (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    exp_t        sb [$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          k        = 0;      // edges since reset release
    logic [15:0] snap_m   = 16'h0;  // frame currently expected on the display

    // Predict the next edge from the stimulus now applied, clock once, compare
    task automatic tick(input string tag);
        exp_t e;
        exp_t got;
        int   kn;
        int   idx;
        logic [3:0] nib;
        e = '0;
        kn = 0;
        if (!rst) begin
            kn = k + 1;
            if (kn >= 2) begin
                idx   = ((kn - 2) / 4) % 4;
                nib   = snap_m[idx*4 +: 4];
                e.dig = 4'(1 << idx);
                e.seg = ((idx % 2) == 1 && nib == 4'h0) ? 7'h00 : hex_tab[nib];
            end
            if (kn == 1 || ((kn - 1) % 16) == 0)
                snap_m = {bus.b_ti_h, bus.b_ti_l, bus.a_ti_h, bus.a_ti_l};
            case ({bus.a_l, bus.b_l})
                2'b10:   e.lamps = 5'b10010;
                2'b01:   e.lamps = 5'b01100;
                2'b00:   e.lamps = 5'b00001;
                default: e.lamps = {4'b0000, 1'(((kn - 1) / 8) % 2)};
            endcase
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        e   = sb.pop_front();
        got = '{bus.dig_en, bus.seg, {bus.a_grn, bus.a_red, bus.b_grn, bus.b_red, bus.amber}};
        k   = kn;
        n_assert++;
        assert (got.dig === e.dig) else begin
            n_fail++;
            $error("FAIL %s_dig k=%0d: got %b expected %b", tag, k, got.dig, e.dig);
        end
        n_assert++;
        assert (got.seg === e.seg) else begin
            n_fail++;
            $error("FAIL %s_seg k=%0d: got %h expected %h", tag, k, got.seg, e.seg);
        end
        n_assert++;
        assert (got.lamps === e.lamps) else begin
            n_fail++;
            $error("FAIL %s_lamps k=%0d: got %b expected %b", tag, k, got.lamps, e.lamps);
        end
        n_assert++;
        assert (!(bus.a_grn && bus.b_grn)) else begin
            n_fail++;
            $error("FAIL %s_grn_excl k=%0d: got a_grn=%b b_grn=%b expected not both 1",
                   tag, k, bus.a_grn, bus.b_grn);
        end
    endtask

    initial begin
        bus.a_ti_l = 4'h3;
        bus.a_ti_h = 4'h0;
        bus.b_ti_l = 4'hA;
        bus.b_ti_h = 4'h1;
        bus.a_l    = 1'b1;
        bus.b_l    = 1'b0;

        // Reset held for three clocks: everything dark
        rst = 1'b1;
        repeat (3) tick("reset");

        // Two full frames of 3/0/A/1, idx1 blanked as a leading zero
        rst = 1'b0;
        repeat (42) tick("scan");

        // Mid-frame change during idx2: rest of this frame must stay on the old snapshot
        bus.a_ti_l = 4'h8;
        bus.b_ti_h = 4'h2;
        repeat (24) tick("midframe");

        // Lamp sequence, plus new timers: idx1 nonzero, idx3 zero (blanked)
        bus.a_ti_h = 4'h5;
        bus.b_ti_h = 4'h0;
        bus.a_l = 1'b0; bus.b_l = 1'b1;
        repeat (3) tick("lamp_s1");
        bus.a_l = 1'b0; bus.b_l = 1'b0;
        repeat (3) tick("lamp_s0");
        bus.a_l = 1'b1; bus.b_l = 1'b1;
        repeat (40) tick("lamp_s3");
        bus.a_l = 1'b1; bus.b_l = 1'b0;
        repeat (3) tick("lamp_s2");

        // Move to a point where idx2 is on display, then reset for one clock
        for (int i = 0; i < 16; i++) begin
            if (k >= 2 && ((k - 2) / 4) % 4 == 2) break;
            tick("align");
        end
        rst = 1'b1;
        bus.a_ti_l = 4'hC;
        bus.b_ti_l = 4'hE;
        tick("midrst");
        rst = 1'b0;
        repeat (20) tick("restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
